// File: rtl/mmr_pkg.sv
// Shared definitions for the multi-mode register: operation codes selected
// by the priority encoder and consumed by the next-value mux.
package mmr_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_HOLD  = 3'd0;
    localparam op_t OP_CLEAR = 3'd1;
    localparam op_t OP_LOAD  = 3'd2;
    localparam op_t OP_INC   = 3'd3;
    localparam op_t OP_DEC   = 3'd4;
    localparam op_t OP_SHL   = 3'd5;
    localparam op_t OP_SHR   = 3'd6;

endpackage

// File: rtl/mmr_op_priority.sv
// Priority encoder turning the raw request lines into a single op code.
// Shared with the register-file control block, so it stays purely combinational.
module mmr_op_priority
    import mmr_pkg::*;
(
    input  logic clear,
    input  logic load,
    input  logic inc,
    input  logic dec,
    input  logic shl,
    input  logic shr,
    output op_t  op
);

    always_comb begin
        op = OP_HOLD;
        if (clear) begin
            op = OP_CLEAR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (inc && dec) begin
            // Opposing arithmetic requests cancel out rather than picking one.
            op = OP_HOLD;
        end else if (inc) begin
            op = OP_INC;
        end else if (dec) begin
            op = OP_DEC;
        end else if (shl) begin
            op = OP_SHL;
        end else if (shr) begin
            op = OP_SHR;
        end
    end

endmodule

// File: rtl/multi_mode_register.sv
// General-purpose datapath register: clear/load, step inc/dec with wrap or
// saturate, logical shifts with serial in/out, status flags and a wrap pulse.
module multi_mode_register
    import mmr_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] step,
    input  logic             clear,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    input  logic             shl,
    input  logic             shr,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             zero,
    output logic             all_ones,
    output logic             wrap_pulse,
    output logic             serial_out
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;

    op_t              op;
    logic [WIDTH-1:0] data_q, data_d;
    logic             wrap_q, wrap_d;
    logic             serial_q, serial_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             carry;
    logic             borrow;

    mmr_op_priority u_op_priority (
        .clear (clear),
        .load  (load),
        .inc   (inc),
        .dec   (dec),
        .shl   (shl),
        .shr   (shr),
        .op    (op)
    );

    // The extra top bit of each intermediate is the carry / borrow out.
    assign sum    = {1'b0, data_q} + {1'b0, step};
    assign diff   = {1'b0, data_q} - {1'b0, step};
    assign carry  = sum[WIDTH];
    assign borrow = diff[WIDTH];

    always_comb begin
        data_d   = data_q;
        wrap_d   = 1'b0;
        serial_d = serial_q;
        case (op)
            OP_CLEAR: begin
                data_d = ALL_ZERO;
            end
            OP_LOAD: begin
                data_d = data_in;
            end
            OP_INC: begin
                wrap_d = carry;
                if (carry && SATURATE) begin
                    data_d = ALL_ONES;
                end else begin
                    data_d = sum[WIDTH-1:0];
                end
            end
            OP_DEC: begin
                wrap_d = borrow;
                if (borrow && SATURATE) begin
                    data_d = ALL_ZERO;
                end else begin
                    data_d = diff[WIDTH-1:0];
                end
            end
            OP_SHL: begin
                data_d   = {data_q[WIDTH-2:0], serial_in};
                serial_d = data_q[WIDTH-1];
            end
            OP_SHR: begin
                data_d   = {serial_in, data_q[WIDTH-1:1]};
                serial_d = data_q[0];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            data_q   <= RESET_VALUE;
            wrap_q   <= 1'b0;
            serial_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            wrap_q   <= wrap_d;
            serial_q <= serial_d;
        end
    end

    // Flags decode the register directly, so they only change after clk edges.
    assign data_out   = data_q;
    assign zero       = (data_q == ALL_ZERO);
    assign all_ones   = (data_q == ALL_ONES);
    assign wrap_pulse = wrap_q;
    assign serial_out = serial_q;

endmodule

// File: tb/tb_multi_mode_register.sv
// Directed bench: one wrap-mode instance (reset value 0x10) and one saturating
// instance driven with the same request stream, checked against hand values.
module tb_multi_mode_register;

    localparam logic [5:0] C  = 6'b100000;
    localparam logic [5:0] L  = 6'b010000;
    localparam logic [5:0] I  = 6'b001000;
    localparam logic [5:0] D  = 6'b000100;
    localparam logic [5:0] SL = 6'b000010;
    localparam logic [5:0] SR = 6'b000001;
    localparam logic [5:0] NO = 6'b000000;

    logic       clk = 1'b0;
    logic       async_reset = 1'b1;
    logic [7:0] data_in = '0;
    logic [7:0] step = '0;
    logic       clear = 1'b0, load = 1'b0, inc = 1'b0, dec = 1'b0;
    logic       shl = 1'b0, shr = 1'b0, serial_in = 1'b0;

    logic [7:0] w_data, s_data;
    logic       w_zero, w_ones, w_wrap, w_so;
    logic       s_zero, s_ones, s_wrap, s_so;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_mode_register #(.WIDTH(8), .RESET_VALUE(8'h10), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .async_reset(async_reset), .data_in(data_in), .step(step),
        .clear(clear), .load(load), .inc(inc), .dec(dec), .shl(shl), .shr(shr),
        .serial_in(serial_in), .data_out(w_data), .zero(w_zero), .all_ones(w_ones),
        .wrap_pulse(w_wrap), .serial_out(w_so)
    );

    multi_mode_register #(.WIDTH(8), .RESET_VALUE(8'h00), .SATURATE(1'b1)) u_sat (
        .clk(clk), .async_reset(async_reset), .data_in(data_in), .step(step),
        .clear(clear), .load(load), .inc(inc), .dec(dec), .shl(shl), .shr(shr),
        .serial_in(serial_in), .data_out(s_data), .zero(s_zero), .all_ones(s_ones),
        .wrap_pulse(s_wrap), .serial_out(s_so)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request for one edge, then sample 1 time unit after it.
    task automatic op(input logic [5:0] ctl, input logic [7:0] din,
                      input logic [7:0] stp, input logic sin);
        {clear, load, inc, dec, shl, shr} = ctl;
        data_in   = din;
        step      = stp;
        serial_in = sin;
        @(posedge clk);
        #1;
        {clear, load, inc, dec, shl, shr} = NO;
    endtask

    initial begin
        #12;
        async_reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_w", w_data, 8'h10);

        // Reset mid-operation
        op(L, 8'h81, 8'h00, 1'b0);
        op(SL, 8'h00, 8'h00, 1'b0);
        check("shl_pre_data", w_data, 8'h02);
        check("shl_pre_so", w_so, 1'b1);
        op(L, 8'h5A, 8'h00, 1'b0);
        check("load_5a", w_data, 8'h5A);
        check("so_holds_on_load", w_so, 1'b1);
        #2;
        async_reset = 1'b1;
        #1;
        check("rst_async_data", w_data, 8'h10);
        check("rst_async_wrap", w_wrap, 1'b0);
        check("rst_async_so", w_so, 1'b0);
        check("rst_async_zero", w_zero, 1'b0);
        check("rst_async_sat_data", s_data, 8'h00);
        check("rst_async_sat_zero", s_zero, 1'b1);
        #3;
        async_reset = 1'b0;

        // Wrap vs saturate on increment and decrement
        op(L, 8'hFE, 8'h00, 1'b0);
        op(I, 8'h00, 8'h03, 1'b0);
        check("w_inc_data", w_data, 8'h01);
        check("w_inc_wrap", w_wrap, 1'b1);
        check("s_inc_data", s_data, 8'hFF);
        check("s_inc_ones", s_ones, 1'b1);
        check("s_inc_wrap", s_wrap, 1'b1);
        op(NO, 8'h00, 8'h00, 1'b0);
        check("w_pulse_one_cycle", w_wrap, 1'b0);
        check("s_pulse_one_cycle", s_wrap, 1'b0);
        op(D, 8'h00, 8'h02, 1'b0);
        check("w_dec_data", w_data, 8'hFF);
        check("w_dec_wrap", w_wrap, 1'b1);
        check("s_dec_data", s_data, 8'hFD);
        check("s_dec_nowrap", s_wrap, 1'b0);

        op(L, 8'h02, 8'h00, 1'b0);
        op(D, 8'h00, 8'h05, 1'b0);
        check("s_dec_sat_data", s_data, 8'h00);
        check("s_dec_sat_zero", s_zero, 1'b1);
        check("s_dec_sat_wrap", s_wrap, 1'b1);
        check("w_dec_wrap_data", w_data, 8'hFD);
        check("w_dec_wrap_pulse", w_wrap, 1'b1);

        op(L, 8'hFD, 8'h00, 1'b0);
        op(I, 8'h00, 8'h02, 1'b0);
        check("s_exact_data", s_data, 8'hFF);
        check("s_exact_wrap", s_wrap, 1'b0);
        check("w_exact_data", w_data, 8'hFF);
        check("w_exact_wrap", w_wrap, 1'b0);
        check("w_exact_ones", w_ones, 1'b1);

        // Back-to-back wrapping increments keep the pulse high
        op(I, 8'h00, 8'h01, 1'b0);
        check("w_b2b1_data", w_data, 8'h00);
        check("w_b2b1_wrap", w_wrap, 1'b1);
        check("s_b2b1_wrap", s_wrap, 1'b1);
        op(I, 8'h00, 8'h01, 1'b0);
        check("w_b2b2_data", w_data, 8'h01);
        check("w_b2b2_wrap", w_wrap, 1'b0);
        check("s_b2b2_data", s_data, 8'hFF);
        check("s_b2b2_wrap", s_wrap, 1'b1);

        // Step of zero is a hold
        op(L, 8'hFF, 8'h00, 1'b0);
        op(I, 8'h00, 8'h00, 1'b0);
        check("step0_data", w_data, 8'hFF);
        check("step0_wrap", w_wrap, 1'b0);

        // Priority
        op(C | L | I, 8'h33, 8'h01, 1'b0);
        check("clr_wins_data", w_data, 8'h00);
        check("clr_wins_zero", w_zero, 1'b1);
        check("clr_no_wrap", w_wrap, 1'b0);
        op(L | I, 8'h33, 8'h01, 1'b0);
        check("load_over_inc", w_data, 8'h33);
        op(I | D, 8'h00, 8'h01, 1'b0);
        check("incdec_hold", w_data, 8'h33);
        check("incdec_wrap", w_wrap, 1'b0);
        op(L, 8'h81, 8'h00, 1'b0);
        check("so_before_shl", w_so, 1'b0);
        op(SL | SR, 8'h00, 8'h00, 1'b1);
        check("shl_wins_data", w_data, 8'h03);
        check("shl_wins_so", w_so, 1'b1);

        // Right shifts with serial_in 0
        op(L, 8'hA5, 8'h00, 1'b0);
        op(SR, 8'h00, 8'h00, 1'b0);
        check("shr1_data", w_data, 8'h52);
        check("shr1_so", w_so, 1'b1);
        op(SR, 8'h00, 8'h00, 1'b0);
        check("shr2_data", w_data, 8'h29);
        check("shr2_so", w_so, 1'b0);
        op(SR, 8'h00, 8'h00, 1'b0);
        check("shr3_data", w_data, 8'h14);
        check("shr3_so", w_so, 1'b1);
        op(SR, 8'h00, 8'h00, 1'b0);
        check("shr4_data", w_data, 8'h0A);
        check("shr4_so", w_so, 1'b0);
        op(NO, 8'h00, 8'h00, 1'b0);
        check("hold_data", w_data, 8'h0A);
        check("hold_so", w_so, 1'b0);
        op(SR, 8'h00, 8'h00, 1'b1);
        check("shr_sin1_data", w_data, 8'h85);
        check("shr_sin1_so", w_so, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
